// File: rtl/twin_reg_arbiter.sv
// Two requesters share write access to two registers (q1/q2) through an
// IDLE/OWN_A/OWN_B arbiter with round-robin ties and a bounded burst length.
module twin_reg_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_a_i,
  input  logic             sel_a_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic             req_b_i,
  input  logic             sel_b_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             clr_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic [WIDTH-1:0] q1_o,
  output logic [WIDTH-1:0] q2_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;
  logic             wr_en;
  logic             wr_sel;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_data = '0;
    case (state_q)
      IDLE: begin
        if (req_a_i && req_b_i) state_d = last_b_q ? OWN_A : OWN_B;
        else if (req_a_i)       state_d = OWN_A;
        else if (req_b_i)       state_d = OWN_B;
      end
      OWN_A: begin
        if (req_a_i) begin
          wr_en   = 1'b1;
          wr_sel  = sel_a_i;
          wr_data = data_a_i;
          // Hand over only when B is actually waiting at the burst limit.
          if (req_b_i && (cnt_q == BURST_LAST)) state_d = OWN_B;
        end else begin
          state_d = req_b_i ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (req_b_i) begin
          wr_en   = 1'b1;
          wr_sel  = sel_b_i;
          wr_data = data_b_i;
          if (req_a_i && (cnt_q == BURST_LAST)) state_d = OWN_A;
        end else begin
          state_d = req_a_i ? OWN_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    if ((state_d == IDLE) || (state_d != state_q)) cnt_d = '0;
    else if (wr_en && (cnt_q < BURST_LAST))       cnt_d = cnt_q + 4'd1;
    if ((state_d == OWN_A) && (state_q != OWN_A)) last_b_d = 1'b0;
    if ((state_d == OWN_B) && (state_q != OWN_B)) last_b_d = 1'b1;
  end

  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    if (clr_i) begin
      q1_d = '0;
      q2_d = '0;
    end else if (wr_en) begin
      if (wr_sel) q2_d = wr_data;
      else        q1_d = wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      q1_q     <= '0;
      q2_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
    end
  end

  assign gnt_a_o = (state_q == OWN_A);
  assign gnt_b_o = (state_q == OWN_B);
  assign busy_o  = (state_q != IDLE);
  assign q1_o    = q1_q;
  assign q2_o    = q2_q;

endmodule

// File: tb/tb_twin_reg_arbiter.sv
// Scoreboard bench for twin_reg_arbiter: expected outputs are queued as each
// cycle's stimulus is driven and compared one clock later.
module tb_twin_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, sel_a = 1'b0, req_b = 1'b0, sel_b = 1'b0, clr = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       gnt_a, gnt_b, busy, gnt_a1, gnt_b1, busy1;
  logic [7:0] q1, q2, q1_1, q2_1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       ga;
    logic       gb;
    logic       bz;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       chk1;
    logic       ga1;
    logic       gb1;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  twin_reg_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_i(req_a), .sel_a_i(sel_a), .data_a_i(data_a),
    .req_b_i(req_b), .sel_b_i(sel_b), .data_b_i(data_b),
    .clr_i(clr),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .q1_o(q1), .q2_o(q2), .busy_o(busy)
  );

  twin_reg_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_i(req_a), .sel_a_i(sel_a), .data_a_i(data_a),
    .req_b_i(req_b), .sel_b_i(sel_b), .data_b_i(data_b),
    .clr_i(clr),
    .gnt_a_o(gnt_a1), .gnt_b_o(gnt_b1), .q1_o(q1_1), .q2_o(q2_1), .busy_o(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic exp_t mk(logic ga, logic gb, logic [7:0] eq1, logic [7:0] eq2);
    exp_t r;
    r = '0;
    r.ga = ga; r.gb = gb; r.bz = ga | gb; r.q1 = eq1; r.q2 = eq2;
    return r;
  endfunction

  task automatic test_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'hFF; data_b = 8'hEE;
    #12;
    n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, 19'h0);
    end
    n_vec++;
    if ({gnt_a1, gnt_b1, busy1, q1_1, q2_1} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_state_mb1 got=%h exp=%h", {gnt_a1, gnt_b1, busy1, q1_1, q2_1}, 19'h0);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    string nm [4] = '{"grant_latency", "first_write_q2", "write_q1", "drop_to_idle"};
    req_a = 1'b1; sel_a = 1'b1; data_a = 8'hA5;
    exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm[0], {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 8'hA5));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm[1], {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    sel_a = 1'b0; data_a = 8'h5A;
    exp_q.push_back(mk(1'b1, 1'b0, 8'h5A, 8'hA5));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm[2], {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    req_a = 1'b0; data_a = 8'h77;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h5A, 8'hA5));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm[3], {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
  endtask

  // Continuous contention: MAX_BURST=4 swaps every 4 edges, MAX_BURST=1 every edge.
  task automatic test_burst();
    logic [7:0] mq1 = 8'h00, mq2 = 8'h00;
    exp_t x;
    pulse_reset();
    req_a = 1'b1; req_b = 1'b1; sel_a = 1'b0; sel_b = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      data_a = 8'(8'h10 + k);
      data_b = 8'(8'h80 + k);
      if (k >= 2) begin
        if ((((k - 2) / 4) % 2) == 0) mq1 = data_a;
        else                          mq2 = data_b;
      end
      x = mk((((k - 1) / 4) % 2) == 0, (((k - 1) / 4) % 2) == 1, mq1, mq2);
      x.chk1 = 1'b1;
      x.ga1  = ((k - 1) % 2) == 0;
      x.gb1  = ((k - 1) % 2) == 1;
      exp_q.push_back(x);
      tick(); e = exp_q.pop_front(); n_vec++;
      if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
        n_err++;
        $display("FAIL burst_k%0d got=%h exp=%h", k, {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
      end
      if (e.chk1) begin
        n_vec++;
        if ({gnt_a1, gnt_b1} !== {e.ga1, e.gb1}) begin
          n_err++;
          $display("FAIL alternate_mb1_k%0d got=%b exp=%b", k, {gnt_a1, gnt_b1}, {e.ga1, e.gb1});
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  // Sole requester keeps ownership past the burst limit; a late B then wins at once.
  task automatic test_no_contention();
    logic [7:0] mq2 = 8'h00;
    pulse_reset();
    req_a = 1'b1; sel_a = 1'b1; req_b = 1'b0; sel_b = 1'b0; data_b = 8'hBB;
    for (int k = 1; k <= 12; k++) begin
      data_a = 8'(8'h40 + k);
      if (k >= 2) mq2 = data_a;
      if (k == 12) req_b = 1'b1;
      exp_q.push_back(mk(k != 12, k == 12, 8'h00, mq2));
      tick(); e = exp_q.pop_front(); n_vec++;
      if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
        n_err++;
        $display("FAIL nocontend_k%0d got=%h exp=%h", k, {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  task automatic test_clr();
    logic       c_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       r_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       s_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] d_v [5] = '{8'h11, 8'h11, 8'h3C, 8'h3C, 8'h99};
    exp_t       x_v [5];
    x_v[0] = mk(1'b1, 1'b0, 8'h00, 8'h00);
    x_v[1] = mk(1'b1, 1'b0, 8'h00, 8'h11);
    x_v[2] = mk(1'b1, 1'b0, 8'h00, 8'h00);
    x_v[3] = mk(1'b1, 1'b0, 8'h3C, 8'h00);
    x_v[4] = mk(1'b0, 1'b0, 8'h00, 8'h00);
    pulse_reset();
    req_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      clr = c_v[k]; req_a = r_v[k]; sel_a = s_v[k]; data_a = d_v[k];
      exp_q.push_back(x_v[k]);
      tick(); e = exp_q.pop_front(); n_vec++;
      if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
        n_err++;
        $display("FAIL clr_step%0d got=%h exp=%h", k, {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    req_a = 1'b0; req_b = 1'b1; sel_b = 1'b1; data_b = 8'h22;
    exp_q.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL own_b_grant got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    exp_q.push_back(mk(1'b0, 1'b1, 8'h00, 8'h22));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL own_b_write got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    req_a = 1'b1; sel_a = 1'b0; data_a = 8'h44; data_b = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== 19'h0) begin
      n_err++;
      $display("FAIL async_reset got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, 19'h0);
    end
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL post_reset_tie got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    exp_q.push_back(mk(1'b1, 1'b0, 8'h44, 8'h00));
    tick(); e = exp_q.pop_front(); n_vec++;
    if ({gnt_a, gnt_b, busy, q1, q2} !== {e.ga, e.gb, e.bz, e.q1, e.q2}) begin
      n_err++;
      $display("FAIL post_reset_write got=%h exp=%h", {gnt_a, gnt_b, busy, q1, q2}, {e.ga, e.gb, e.bz, e.q1, e.q2});
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_burst();
    test_no_contention();
    test_clr();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
